// File: rtl/otter_memory.sv
// otter_memory: 64 KiB main memory with a direct instruction port and a
// direct-mapped write-back data cache (16 lines x 4 words) plus uncached IO.
module otter_memory (
    input  logic        MEM_CLK,
    input  logic        MEM_RST,
    input  logic        MEM_RDEN1,
    input  logic [13:0] MEM_ADDR1,
    input  logic        MEM_RDEN2,
    input  logic        MEM_WE2,
    input  logic [31:0] MEM_ADDR2,
    input  logic [31:0] MEM_DIN2,
    input  logic [1:0]  MEM_SIZE,
    input  logic        MEM_SIGN,
    input  logic [31:0] IO_IN,
    output logic        IO_WR,
    output logic [31:0] MEM_DOUT1,
    output logic [31:0] MEM_DOUT2,
    output logic        MEM_VALID1,
    output logic        MEM_VALID2,
    output logic        ERR
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] mem_q   [0:16383];
    logic [31:0] cdata_q [0:63];
    logic [7:0]  ctag_q  [0:15];
    logic [15:0] cvalid_q, cdirty_q;
    logic [31:0] fill_q;
    logic [31:0] dout1_q, dout2_q;
    logic        valid1_q, valid2_q, err_q, io_wr_q;

    logic        req, is_st, is_io, bad, hit;
    logic [3:0]  idx;
    logic [7:0]  tag;
    logic [1:0]  wsel, fill_w;
    logic [31:0] cword, wlane, wdata, ldata;
    logic [3:0]  be;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        st_we, fill_we, tag_we;

    assign idx    = MEM_ADDR2[7:4];
    assign tag    = MEM_ADDR2[15:8];
    assign wsel   = MEM_ADDR2[3:2];
    assign req    = MEM_RDEN2 | MEM_WE2;
    assign is_st  = MEM_WE2;
    assign is_io  = MEM_ADDR2 >= 32'h1100_0000;
    assign bad    = (MEM_SIZE == 2'd3)
                  | ((MEM_SIZE == 2'd1) & MEM_ADDR2[0])
                  | ((MEM_SIZE == 2'd2) & (|MEM_ADDR2[1:0]))
                  | (!is_io & (|MEM_ADDR2[31:16]));
    assign hit    = cvalid_q[idx] & (ctag_q[idx] == tag);
    assign cword  = cdata_q[{idx, wsel}];
    assign fill_w = cnt_q[1:0] - 2'd1;

    // Store lane merge and load extraction on the addressed cache word
    always_comb begin
        be     = 4'b1111;
        wlane  = MEM_DIN2;
        ldata  = cword;
        byte_v = cword[{MEM_ADDR2[1:0], 3'b000} +: 8];
        half_v = MEM_ADDR2[1] ? cword[31:16] : cword[15:0];
        case (MEM_SIZE)
            2'd0: begin
                be    = 4'b0001 << MEM_ADDR2[1:0];
                wlane = {4{MEM_DIN2[7:0]}};
                ldata = MEM_SIGN ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            2'd1: begin
                be    = MEM_ADDR2[1] ? 4'b1100 : 4'b0011;
                wlane = {2{MEM_DIN2[15:0]}};
                ldata = MEM_SIGN ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: ;
        endcase
        wdata = cword;
        for (int i = 0; i < 4; i++)
            if (be[i]) wdata[8*i +: 8] = wlane[8*i +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad | is_io | hit)
                        state_d = DONE;
                    else if (cvalid_q[idx] & cdirty_q[idx])
                        state_d = WRITEBACK;
                    else
                        state_d = FILL;
                end
            end
            WRITEBACK: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd3) begin
                    state_d = FILL;
                    cnt_d   = 3'd0;
                end
            end
            FILL: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign st_we   = (state_q == IDLE) & req & !bad & !is_io & hit & is_st;
    assign fill_we = (state_q == FILL) & (cnt_q != 3'd0);
    assign tag_we  = (state_q == FILL) & (cnt_q == 3'd4);

    // Main memory and cache arrays keep contents across reset
    always_ff @(posedge MEM_CLK) begin
        if (!MEM_RST && state_q == WRITEBACK)
            mem_q[{ctag_q[idx], idx, cnt_q[1:0]}] <= cdata_q[{idx, cnt_q[1:0]}];
        fill_q <= mem_q[{tag, idx, cnt_q[1:0]}];
    end

    always_ff @(posedge MEM_CLK) begin
        if (!MEM_RST) begin
            if (st_we)
                cdata_q[{idx, wsel}] <= wdata;
            if (fill_we)
                cdata_q[{idx, fill_w}] <= fill_q;
            if (tag_we)
                ctag_q[idx] <= tag;
        end
    end

    always_ff @(posedge MEM_CLK) begin
        if (MEM_RST) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            cvalid_q <= 16'h0;
            cdirty_q <= 16'h0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            err_q    <= 1'b0;
            io_wr_q  <= 1'b0;
            dout1_q  <= 32'h0;
            dout2_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid1_q <= MEM_RDEN1;
            if (MEM_RDEN1)
                dout1_q <= mem_q[MEM_ADDR1];
            valid2_q <= 1'b0;
            err_q    <= 1'b0;
            io_wr_q  <= 1'b0;
            if (state_q == IDLE && req) begin
                if (bad) begin
                    err_q <= 1'b1;
                end else if (is_io) begin
                    valid2_q <= 1'b1;
                    io_wr_q  <= is_st;
                    if (!is_st)
                        dout2_q <= IO_IN;
                end else if (hit) begin
                    valid2_q <= 1'b1;
                    if (is_st)
                        cdirty_q[idx] <= 1'b1;
                    else
                        dout2_q <= ldata;
                end else begin
                    cvalid_q[idx] <= 1'b0;
                end
            end
            if (tag_we) begin
                cvalid_q[idx] <= 1'b1;
                cdirty_q[idx] <= 1'b0;
            end
        end
    end

    assign MEM_DOUT1  = dout1_q;
    assign MEM_DOUT2  = dout2_q;
    assign MEM_VALID1 = valid1_q;
    assign MEM_VALID2 = valid2_q;
    assign ERR        = err_q;
    assign IO_WR      = io_wr_q;

endmodule

// File: tb/tb_otter_memory.sv
// tb_otter_memory: directed and random round-trip checks of otter_memory,
// covering cache hit/miss/eviction timing, errors, IO and reset abort.
module tb_otter_memory;
    logic        clk = 1'b0;
    logic        rst;
    logic        rden1;
    logic [13:0] addr1;
    logic        rden2, we2;
    logic [31:0] addr2, din2, io_in;
    logic [1:0]  size;
    logic        sign;
    logic        io_wr, valid1, valid2, err;
    logic [31:0] dout1, dout2;

    int          tests = 0;
    int          fails = 0;
    int          r_lat;
    logic        r_v, r_err, r_io, r_after, first_v, seen;
    logic [31:0] ra, rd, rexp;
    logic [1:0]  rsz;

    always #5 clk = ~clk;

    otter_memory dut (
        .MEM_CLK    (clk),
        .MEM_RST    (rst),
        .MEM_RDEN1  (rden1),
        .MEM_ADDR1  (addr1),
        .MEM_RDEN2  (rden2),
        .MEM_WE2    (we2),
        .MEM_ADDR2  (addr2),
        .MEM_DIN2   (din2),
        .MEM_SIZE   (size),
        .MEM_SIGN   (sign),
        .IO_IN      (io_in),
        .IO_WR      (io_wr),
        .MEM_DOUT1  (dout1),
        .MEM_DOUT2  (dout2),
        .MEM_VALID1 (valid1),
        .MEM_VALID2 (valid2),
        .ERR        (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One data-port request held until VALID2/ERR, bounded at 20 cycles
    task automatic access(input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz,
                          input logic sg);
        @(negedge clk);
        we2   = we;
        rden2 = !we;
        addr2 = a;
        din2  = d;
        size  = sz;
        sign  = sg;
        #1 first_v = valid2 | err;
        r_lat = 0;
        r_v   = 1'b0;
        r_err = 1'b0;
        r_io  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 r_lat++;
            if (valid2 || err) begin
                r_v   = valid2;
                r_err = err;
                r_io  = io_wr;
                break;
            end
        end
        @(negedge clk);
        we2   = 1'b0;
        rden2 = 1'b0;
        @(posedge clk);
        #1 r_after = valid2 | err | io_wr;
    endtask

    initial begin
        rst   = 1'b1;
        rden1 = 1'b0;
        addr1 = '0;
        rden2 = 1'b0;
        we2   = 1'b0;
        addr2 = '0;
        din2  = '0;
        io_in = '0;
        size  = 2'd2;
        sign  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst valid1", {31'h0, valid1}, 32'h0);
        chk("rst valid2", {31'h0, valid2}, 32'h0);
        chk("rst err", {31'h0, err}, 32'h0);
        chk("rst io_wr", {31'h0, io_wr}, 32'h0);
        chk("rst dout1", dout1, 32'h0);
        chk("rst dout2", dout2, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Word round trip: clean miss then hit
        access(1'b1, 32'h1234, 32'hDEADBEEF, 2'd2, 1'b0);
        chk("st1234 first", {31'h0, first_v}, 32'h0);
        chk("st1234 valid", {31'h0, r_v}, 32'h1);
        chk("st1234 lat", r_lat, 32'd7);
        chk("st1234 pulse", {31'h0, r_after}, 32'h0);
        access(1'b0, 32'h1234, 32'h0, 2'd2, 1'b0);
        chk("ld1234 lat", r_lat, 32'd1);
        chk("ld1234 data", dout2, 32'hDEADBEEF);
        chk("ld1234 pulse", {31'h0, r_after}, 32'h0);

        // Byte lane 3 with sign/zero extension
        access(1'b1, 32'h0040, 32'h0, 2'd2, 1'b0);
        access(1'b1, 32'h0043, 32'h0000_0080, 2'd0, 1'b0);
        chk("stb43 lat", r_lat, 32'd1);
        access(1'b0, 32'h0043, 32'h0, 2'd0, 1'b0);
        chk("ldb43 signed", dout2, 32'hFFFFFF80);
        access(1'b0, 32'h0043, 32'h0, 2'd0, 1'b1);
        chk("ldb43 unsigned", dout2, 32'h00000080);
        access(1'b0, 32'h0040, 32'h0, 2'd2, 1'b0);
        chk("ldw40", dout2, 32'h80000000);

        // Upper half
        access(1'b1, 32'h0102, 32'h0000_8001, 2'd1, 1'b0);
        chk("sth102 lat", r_lat, 32'd7);
        access(1'b0, 32'h0102, 32'h0, 2'd1, 1'b1);
        chk("ldh102 unsigned", dout2, 32'h00008001);
        access(1'b0, 32'h0102, 32'h0, 2'd1, 1'b0);
        chk("ldh102 signed", dout2, 32'hFFFF8001);

        // Dirty evictions on index 0
        access(1'b1, 32'h0000, 32'h11111111, 2'd2, 1'b0);
        chk("st0 dirty lat", r_lat, 32'd11);
        access(1'b1, 32'h0100, 32'h22222222, 2'd2, 1'b0);
        chk("st100 dirty lat", r_lat, 32'd11);
        access(1'b0, 32'h0000, 32'h0, 2'd2, 1'b0);
        chk("ld0 lat", r_lat, 32'd11);
        chk("ld0 data", dout2, 32'h11111111);
        @(negedge clk);
        rden1 = 1'b1;
        addr1 = 14'h0;
        @(posedge clk);
        #1;
        chk("ifetch valid", {31'h0, valid1}, 32'h1);
        chk("ifetch data", dout1, 32'h11111111);
        @(negedge clk);
        rden1 = 1'b0;
        @(posedge clk);
        #1 chk("ifetch pulse", {31'h0, valid1}, 32'h0);

        // Error cases
        access(1'b0, 32'h0002, 32'h0, 2'd2, 1'b0);
        chk("misw err", {31'h0, r_err}, 32'h1);
        chk("misw novalid", {31'h0, r_v}, 32'h0);
        chk("misw dout", dout2, 32'h11111111);
        chk("misw pulse", {31'h0, r_after}, 32'h0);
        access(1'b1, 32'h0001, 32'hFFFF_FFFF, 2'd1, 1'b0);
        chk("mish err", {31'h0, r_err}, 32'h1);
        access(1'b0, 32'h0000, 32'h0, 2'd3, 1'b0);
        chk("size3 err", {31'h0, r_err}, 32'h1);
        access(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 2'd2, 1'b0);
        chk("hole err", {31'h0, r_err}, 32'h1);
        access(1'b0, 32'h0000, 32'h0, 2'd2, 1'b0);
        chk("err nochange", dout2, 32'h11111111);

        // IO window
        access(1'b1, 32'h1100_0000, 32'h12345678, 2'd2, 1'b0);
        chk("io st valid", {31'h0, r_v}, 32'h1);
        chk("io st wr", {31'h0, r_io}, 32'h1);
        chk("io st pulse", {31'h0, r_after}, 32'h0);
        io_in = 32'hCAFEF00D;
        access(1'b0, 32'h1100_0000, 32'h0, 2'd2, 1'b0);
        chk("io ld valid", {31'h0, r_v}, 32'h1);
        chk("io ld wr", {31'h0, r_io}, 32'h0);
        chk("io ld data", dout2, 32'hCAFEF00D);

        // Random round trips for each size and extension mode
        for (int s = 0; s < 3; s++) begin
            for (int g = 0; g < 2; g++) begin
                for (int n = 0; n < 100; n++) begin
                    rsz = s[1:0];
                    ra  = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
                    if (s == 0)
                        ra[1:0] = 2'($urandom_range(0, 3));
                    if (s == 1)
                        ra[1] = 1'($urandom_range(0, 1));
                    rd = $urandom;
                    if (s == 0)
                        rexp = g[0] ? {24'h0, rd[7:0]}
                                    : {{24{rd[7]}}, rd[7:0]};
                    else if (s == 1)
                        rexp = g[0] ? {16'h0, rd[15:0]}
                                    : {{16{rd[15]}}, rd[15:0]};
                    else
                        rexp = rd;
                    access(1'b1, ra, rd, rsz, 1'b0);
                    access(1'b0, ra, 32'h0, rsz, g[0]);
                    chk("rnd valid", {31'h0, r_v}, 32'h1);
                    chk("rnd data", dout2, rexp);
                end
            end
        end

        // Reset during a dirty-miss fill keeps written-back words
        access(1'b1, 32'h2000, 32'hA5A5A5A5, 2'd2, 1'b0);
        chk("abort prep", {31'h0, r_v}, 32'h1);
        @(negedge clk);
        rden2 = 1'b1;
        we2   = 1'b0;
        addr2 = 32'h3000;
        size  = 2'd2;
        seen  = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1 seen = seen | valid2 | err;
        end
        chk("abort novalid", {31'h0, seen}, 32'h0);
        @(negedge clk);
        rst   = 1'b1;
        rden2 = 1'b0;
        @(posedge clk);
        #1;
        chk("abort rst dout2", dout2, 32'h0);
        chk("abort rst valid2", {31'h0, valid2}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 32'h2000, 32'h0, 2'd2, 1'b0);
        chk("abort reload lat", r_lat, 32'd7);
        chk("abort reload data", dout2, 32'hA5A5A5A5);

        // Reset drops dirty data without writeback
        access(1'b1, 32'h2000, 32'h5A5A5A5A, 2'd2, 1'b0);
        chk("dirty hit lat", r_lat, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        access(1'b0, 32'h2000, 32'h0, 2'd2, 1'b0);
        chk("nowb lat", r_lat, 32'd7);
        chk("nowb data", dout2, 32'hA5A5A5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/otter_memory.md
OTTER_MEMORY -- requirements
Module: otter_memory

Interface
REQ-001 SHALL provide ports: MEM_CLK in 1 (sole clock, rising edge); MEM_RST in 1 (reset).
REQ-002 SHALL provide: MEM_RDEN1 in 1 (instruction read enable); MEM_ADDR1 in 14 (instruction word address, PC[15:2]).
REQ-003 SHALL provide: MEM_RDEN2 in 1 (data read enable); MEM_WE2 in 1 (data write enable); MEM_ADDR2 in 32 (data byte address); MEM_DIN2 in 32 (store data, also IO write data).
REQ-004 SHALL provide: MEM_SIZE in 2 (0 byte, 1 half, 2 word); MEM_SIGN in 1 (1 unsigned, 0 signed); IO_IN in 32 (IO read data).
REQ-005 SHALL provide outputs: IO_WR 1 (IO write strobe); MEM_DOUT1 32 (instruction); MEM_DOUT2 32 (load data); MEM_VALID1 1; MEM_VALID2 1; ERR 1.
REQ-006 One clock; reset is synchronous and active-high.

Function
REQ-007 Main memory SHALL be 16384 x 32-bit words (byte addresses 0x0000-0xFFFF), zero-initialised at power-up, not cleared by reset.
REQ-008 Instruction port SHALL read main memory directly: MEM_DOUT1 and MEM_VALID1 registered, valid one cycle after MEM_RDEN1 high; no coherence with dirty data-cache lines.
REQ-009 Data port SHALL use a direct-mapped, write-back, write-allocate cache: 16 lines x 4 words; offset ADDR2[3:0], index ADDR2[7:4], tag ADDR2[15:8]; per-line valid and dirty bits.
REQ-010 Request = MEM_RDEN2 or MEM_WE2 high (WE2 priority if both); inputs held stable by requester until MEM_VALID2 seen.
REQ-011 MEM_VALID2 SHALL be a registered one-cycle pulse marking completion; never high while idle; never high combinationally in the request's first cycle.
REQ-012 FSM states: IDLE, WRITEBACK, FILL, DONE.
REQ-013 IDLE with request and hit: load captures data into MEM_DOUT2 / store updates selected byte lanes and sets dirty, at that edge; -> DONE (VALID2 high next cycle).
REQ-014 IDLE miss with dirty valid victim -> WRITEBACK (4 cycles, one victim word per cycle to main memory) -> FILL; clean/invalid miss -> FILL directly.
REQ-015 FILL SHALL read 4 words (synchronous 1-cycle memory latency, 5 cycles), set valid, clear dirty, write tag, -> IDLE, where request re-evaluates as hit.
REQ-016 DONE SHALL last one cycle with MEM_VALID2=1, then IDLE; request still asserted in DONE is not re-executed.
REQ-017 Store lanes: byte -> lane ADDR2[1:0] from DIN2[7:0]; half -> lanes per ADDR2[1] from DIN2[15:0]; word -> all lanes.
REQ-018 Load extraction: selected byte/half zero-extended when MEM_SIGN=1, sign-extended when 0; word unchanged; MEM_DOUT2 held until next load completes.
REQ-019 ERR SHALL pulse one cycle in place of MEM_VALID2 (no memory change, DOUT2 unchanged) for: half at odd address, word not 4-aligned, MEM_SIZE=3, address 0x00010000-0x10FFFFFF.
REQ-020 Addresses >= 0x11000000 are uncached IO: store pulses IO_WR one cycle with DONE; load latches IO_IN into MEM_DOUT2; both complete via DONE.
REQ-021 Worst-case data latency (dirty miss) SHALL be <= 12 cycles from request to VALID2.

Reset
REQ-022 Synchronous MEM_RST SHALL: clear all cache valid and dirty bits (no writeback), FSM -> IDLE, MEM_VALID1/2, ERR, IO_WR -> 0, MEM_DOUT1/2 -> 0.
REQ-023 Reset mid-transaction SHALL abort it; partially filled line stays invalid; main memory keeps words already written back.

Verification
REQ-024 Store word 0xDEADBEEF @0x1234, then load word -> MEM_DOUT2=0xDEADBEEF, VALID2 one cycle each.
REQ-025 Store byte 0x80 @0x0043; load byte SIGN=0 -> 0xFFFFFF80; SIGN=1 -> 0x00000080; word @0x0040 shows 0x80 in bits[31:24].
REQ-026 Store half 0x8001 @0x0102; load half SIGN=1 -> 0x00008001; SIGN=0 -> 0xFFFF8001.
REQ-027 Store word 0x11111111 @0x0000, store 0x22222222 @0x0100 (same index, evicts dirty), load @0x0000 -> 0x11111111; instruction read MEM_ADDR1=0 then -> 0x11111111 after second eviction.
REQ-028 Load word @0x0002 -> ERR pulse, no VALID2; store @0x11000000 -> IO_WR pulse; load there with IO_IN=0xCAFEF00D -> DOUT2=0xCAFEF00D.
REQ-029 100 random store/load pairs per size/sign over 0x0000-0xFFFF -> all round-trip with correct extension.
